// File: rtl/dsp_nco_sweep.sv
// dsp_nco_sweep
// Frequency-sweep controller that drives an NCO's frequency control word and
// enable. A start pulse latches the configuration and steps phi_inc from
// f_start by f_step, holding each word for dwell+1 cycles. It runs single-shot
// or continuous.
//
// Build option: define DSP_NCO_SWEEP_TRI_EN for a triangle sweep in continuous
// mode, where the direction reverses at each endpoint. When it is undefined,
// continuous mode is a sawtooth that reloads f_start at the end of each pass.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin a sweep (sampled only in IDLE)
//   stop       in   abort the sweep; wins over start and over a sweep end
//   repeat_en  in   0 = single sweep, 1 = continuous
//                   (named repeat_en because `repeat` is a reserved word)
//   f_start    in   first frequency word
//   f_step     in   unsigned per-step increment
//   step_num   in   number of increments per sweep
//   dwell      in   extra hold cycles per word
//   phi_inc    out  frequency word to the NCO (registered)
//   nco_en     out  NCO enable (registered)
//   busy       out  high while sweeping
//   step_idx   out  index of the current word in the pass
//   wrap       out  one-cycle pulse on the first word of each new continuous pass
//   done       out  one-cycle pulse at the natural end of a single sweep
//
// state | meaning
// IDLE  | outputs parked at zero, waiting for start
// RUN   | sweeping; only latched configuration is used
module dsp_nco_sweep #(
  parameter int PHI_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 repeat_en,
  input  logic [PHI_WIDTH-1:0] f_start,
  input  logic [PHI_WIDTH-1:0] f_step,
  input  logic [CNT_WIDTH-1:0] step_num,
  input  logic [CNT_WIDTH-1:0] dwell,
  output logic [PHI_WIDTH-1:0] phi_inc,
  output logic                 nco_en,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] step_idx,
  output logic                 wrap,
  output logic                 done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [PHI_WIDTH-1:0]   phi_q, phi_d;
  logic                   en_q, en_d;
  logic                   busy_q, busy_d;
  logic [CNT_WIDTH-1:0]   idx_q, idx_d;
  logic                   wrap_q, wrap_d;
  logic                   done_q, done_d;
  logic [CNT_WIDTH-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic                   dir_q, dir_d;
  logic [PHI_WIDTH-1:0]   f_start_q, f_start_d;
  logic [PHI_WIDTH-1:0]   f_step_q, f_step_d;
  logic [CNT_WIDTH-1:0]   step_num_q, step_num_d;
  logic [CNT_WIDTH-1:0]   dwell_q, dwell_d;
  logic                   rpt_q, rpt_d;

  // Modulo 2^PHI_WIDTH on purpose: phase words are circular.
  logic [PHI_WIDTH-1:0]   phi_up, phi_dn;
  assign phi_up = phi_q + f_step_q;
  assign phi_dn = phi_q - f_step_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phi_q       <= '0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      idx_q       <= '0;
      wrap_q      <= 1'b0;
      done_q      <= 1'b0;
      dwell_cnt_q <= '0;
      dir_q       <= 1'b0;
      f_start_q   <= '0;
      f_step_q    <= '0;
      step_num_q  <= '0;
      dwell_q     <= '0;
      rpt_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phi_q       <= phi_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      idx_q       <= idx_d;
      wrap_q      <= wrap_d;
      done_q      <= done_d;
      dwell_cnt_q <= dwell_cnt_d;
      dir_q       <= dir_d;
      f_start_q   <= f_start_d;
      f_step_q    <= f_step_d;
      step_num_q  <= step_num_d;
      dwell_q     <= dwell_d;
      rpt_q       <= rpt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phi_d       = phi_q;
    en_d        = en_q;
    busy_d      = busy_q;
    idx_d       = idx_q;
    wrap_d      = 1'b0;
    done_d      = 1'b0;
    dwell_cnt_d = dwell_cnt_q;
    dir_d       = dir_q;
    f_start_d   = f_start_q;
    f_step_d    = f_step_q;
    step_num_d  = step_num_q;
    dwell_d     = dwell_q;
    rpt_d       = rpt_q;

    if (stop) begin
      state_d     = IDLE;
      phi_d       = '0;
      en_d        = 1'b0;
      busy_d      = 1'b0;
      idx_d       = '0;
      dwell_cnt_d = '0;
      dir_d       = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          phi_d  = '0;
          en_d   = 1'b0;
          busy_d = 1'b0;
          idx_d  = '0;
          if (start) begin
            f_start_d   = f_start;
            f_step_d    = f_step;
            step_num_d  = step_num;
            dwell_d     = dwell;
            rpt_d       = repeat_en;
            phi_d       = f_start;
            en_d        = 1'b1;
            busy_d      = 1'b1;
            idx_d       = '0;
            dwell_cnt_d = '0;
            dir_d       = 1'b0;
            state_d     = RUN;
          end
        end
        RUN: begin
          if (dwell_cnt_q != dwell_q) begin
            dwell_cnt_d = dwell_cnt_q + CNT_WIDTH'(1);
          end else begin
            dwell_cnt_d = '0;
            if (idx_q < step_num_q) begin
              idx_d = idx_q + CNT_WIDTH'(1);
              phi_d = dir_q ? phi_dn : phi_up;
            end else if (!rpt_q) begin
              state_d = IDLE;
              phi_d   = '0;
              en_d    = 1'b0;
              busy_d  = 1'b0;
              idx_d   = '0;
              dir_d   = 1'b0;
              done_d  = 1'b1;
            end else begin
              wrap_d = 1'b1;
`ifdef DSP_NCO_SWEEP_TRI_EN
              if (step_num_q == '0) begin
                // A zero-length pass has no other endpoint to turn toward.
                phi_d = f_start_q;
                idx_d = '0;
              end else begin
                // Turn around and step straight away so the endpoint word is
                // not held for a second dwell.
                dir_d = ~dir_q;
                idx_d = CNT_WIDTH'(1);
                phi_d = dir_q ? phi_up : phi_dn;
              end
`else
              phi_d = f_start_q;
              idx_d = '0;
`endif
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign phi_inc  = phi_q;
  assign nco_en   = en_q;
  assign busy     = busy_q;
  assign step_idx = idx_q;
  assign wrap     = wrap_q;
  assign done     = done_q;

endmodule

// File: tb/tb_dsp_nco_sweep.sv
// Directed testbench for dsp_nco_sweep. Inputs change and outputs are sampled
// on the falling edge. Continuous-mode expectations follow the build option
// DSP_NCO_SWEEP_TRI_EN.
module tb_dsp_nco_sweep;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        repeat_en;
  logic [31:0] f_start;
  logic [31:0] f_step;
  logic [15:0] step_num;
  logic [15:0] dwell;
  logic [31:0] phi_inc;
  logic        nco_en;
  logic        busy;
  logic [15:0] step_idx;
  logic        wrap;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  dsp_nco_sweep #(.PHI_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .repeat_en (repeat_en),
    .f_start   (f_start),
    .f_step    (f_step),
    .step_num  (step_num),
    .dwell     (dwell),
    .phi_inc   (phi_inc),
    .nco_en    (nco_en),
    .busy      (busy),
    .step_idx  (step_idx),
    .wrap      (wrap),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".phi"},  64'(phi_inc),  64'h0);
    chk({tag, ".en"},   64'(nco_en),   64'h0);
    chk({tag, ".busy"}, 64'(busy),     64'h0);
    chk({tag, ".idx"},  64'(step_idx), 64'h0);
    chk({tag, ".wrap"}, 64'(wrap),     64'h0);
    chk({tag, ".done"}, 64'(done),     64'h0);
  endtask

  task automatic set_cfg(input logic [31:0] fs, input logic [31:0] st,
                         input logic [15:0] sn, input logic [15:0] dw, input logic rp);
    f_start   = fs;
    f_step    = st;
    step_num  = sn;
    dwell     = dw;
    repeat_en = rp;
  endtask

  logic [31:0] sgl_phi [8] = '{32'd100, 32'd100, 32'd110, 32'd110, 32'd120, 32'd120, 32'd130, 32'd130};
  logic [15:0] sgl_idx [8] = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd3};
`ifdef DSP_NCO_SWEEP_TRI_EN
  logic [31:0] cont_phi  [10] = '{32'd0, 32'd5, 32'd10, 32'd5, 32'd0, 32'd5, 32'd10, 32'd5, 32'd0, 32'd5};
  logic        cont_wrap [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
  logic [31:0] cont_phi  [10] = '{32'd0, 32'd5, 32'd10, 32'd0, 32'd5, 32'd10, 32'd0, 32'd5, 32'd10, 32'd0};
  logic        cont_wrap [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cnt;
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    set_cfg(32'd0, 32'd0, 16'd0, 16'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single sweep: 100 +10, 3 steps, dwell 1.
    set_cfg(32'd100, 32'd10, 16'd3, 16'd1, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    set_cfg(32'd999, 32'd1, 16'd9, 16'd9, 1'b1); // must be ignored in RUN
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("single.phi[%0d]", i), 64'(phi_inc), 64'(sgl_phi[i]));
      chk($sformatf("single.idx[%0d]", i), 64'(step_idx), 64'(sgl_idx[i]));
      chk($sformatf("single.en[%0d]", i),  64'(nco_en), 64'h1);
      chk($sformatf("single.done[%0d]", i), 64'(done), 64'h0);
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    chk("single.busy_cycles", 64'(busy_cnt), 64'd8);
    chk("single.end_phi",  64'(phi_inc), 64'h0);
    chk("single.end_en",   64'(nco_en),  64'h0);
    chk("single.end_busy", 64'(busy),    64'h0);
    chk("single.done",     64'(done),    64'h1);

    // New start accepted in the done cycle: wrap-around sweep.
    set_cfg(32'hFFFF_FFF0, 32'h20, 16'd1, 16'd0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_after",   64'(done),    64'h0);
    chk("wrapv.phi0",   64'(phi_inc), 64'hFFFF_FFF0);
    chk("wrapv.en0",    64'(nco_en),  64'h1);
    @(negedge clk);
    chk("wrapv.phi1",   64'(phi_inc), 64'h0000_0010);
    chk("wrapv.idx1",   64'(step_idx), 64'h1);
    @(negedge clk);
    chk("wrapv.phi_end", 64'(phi_inc), 64'h0);
    chk("wrapv.done",    64'(done),    64'h1);
    @(negedge clk);

    // Zero step_num: one word held dwell+1 = 3 cycles.
    set_cfg(32'd7, 32'd3, 16'd0, 16'd2, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("zero.phi[%0d]", i), 64'(phi_inc), 64'd7);
      chk($sformatf("zero.done[%0d]", i), 64'(done), 64'h0);
      @(negedge clk);
    end
    chk("zero.done", 64'(done),   64'h1);
    chk("zero.en",   64'(nco_en), 64'h0);
    @(negedge clk);

    // Continuous sweep, then stop.
    set_cfg(32'd0, 32'd5, 16'd2, 16'd0, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("cont.phi[%0d]", i),  64'(phi_inc), 64'(cont_phi[i]));
      chk($sformatf("cont.wrap[%0d]", i), 64'(wrap),    64'(cont_wrap[i]));
      chk($sformatf("cont.busy[%0d]", i), 64'(busy),    64'h1);
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk_idle("cont_stop");

    // Abort with stop and start together in cycle 3.
    set_cfg(32'd100, 32'd10, 16'd3, 16'd1, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort.pre_phi", 64'(phi_inc), 64'd110);
    stop = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk_idle("abort");
    start = 1'b1;            // start with stop still high in IDLE
    @(negedge clk);
    chk_idle("abort_start_blocked");
    stop = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk_idle("abort_after");

    // Reset mid-run, then a fresh start.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstrun.pre_en", 64'(nco_en), 64'h1);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("rst_run");
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("restart.phi[%0d]", i), 64'(phi_inc), 64'(sgl_phi[i]));
      @(negedge clk);
    end
    chk("restart.done", 64'(done), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
